// File: rtl/command_initiator.sv
// Purpose  : UART command master. Sends a command/address(/data) frame to a
//            responder, then collects reply bytes until the line goes quiet.
// Latency  : o_busy one cycle after an accepted i_start; o_done RESP_TIMEOUT
//            cycles after the last stop bit (or after the last reply byte).
// Backpres.: none; i_start is only honoured in IDLE and dropped otherwise.
//
// Ports:
//   sys_clk, sw_0       clock, asynchronous active-low reset
//   i_start             one-cycle request; i_command/i_address/i_data latched
//   i_rx / o_tx         8N1 serial from / to the responder
//   o_busy, o_done      transaction in flight / one-cycle completion pulse
//   o_status            00 write ok, 01 read data, 10 device error, 11 protocol
//   o_error_code        low two bits of a device error byte
//   o_rdata             last word returned by a successful read
module command_initiator #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RESP_TIMEOUT = 200000
) (
  input  logic        sys_clk,
  input  logic        sw_0,
  input  logic        i_start,
  input  logic [7:0]  i_command,
  input  logic [14:0] i_address,
  input  logic [31:0] i_data,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_status,
  output logic [1:0]  o_error_code,
  output logic [31:0] o_rdata
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(RESP_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX_BYTE = 2'd1,
    S_RESP    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic [7:0]  r_cmd;
  logic [14:0] r_addr;
  logic [31:0] r_data;

  // Transmitter
  logic [CW-1:0] r_tx_clk;
  logic [3:0]    r_tx_bit;   // 0 start, 1..8 data, 9 stop
  logic [2:0]    r_tx_byte;
  logic [2:0]    w_last_byte;
  logic [7:0]    w_frame_byte;
  logic [3:0]    w_bit_m1;
  logic          w_tx_bit;
  logic          w_tx_bit_end;
  logic          w_tx_frame_end;

  // Receiver
  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          r_rx_active;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bitn;
  logic [7:0]    r_rx_sh;
  logic          r_rx_vld;
  logic [7:0]    r_rx_dat;

  // Response collection
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_byte_cnt;
  logic [31:0]   r_shift;
  logic          w_tmo_expire;
  logic          w_accept;
  logic          w_err_byte;

  // Results
  logic [1:0]  r_status;
  logic [1:0]  r_err;
  logic [31:0] r_rdata;

  assign w_accept       = (r_state == S_IDLE) && i_start;
  assign w_last_byte    = (r_cmd == 8'h00) ? 3'd6 : 3'd2;
  assign w_tx_bit_end   = (r_tx_clk == BIT_LAST);
  assign w_tx_frame_end = (r_state == S_TX_BYTE) && w_tx_bit_end &&
                          (r_tx_bit == 4'd9) && (r_tx_byte == w_last_byte);
  // A byte landing in the same cycle reloads the window instead of closing it.
  assign w_tmo_expire   = (r_state == S_RESP) && !r_rx_vld && (r_tmo <= TW'(1));
  assign w_err_byte     = (r_shift[7:0] >= 8'h01) && (r_shift[7:0] <= 8'h03);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept)       w_state_nxt = S_TX_BYTE;
      S_TX_BYTE: if (w_tx_frame_end) w_state_nxt = S_RESP;
      S_RESP:    if (w_tmo_expire)   w_state_nxt = S_DONE;
      S_DONE:                        w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state == S_TX_BYTE) || (r_state == S_RESP);
  assign o_done = (r_state == S_DONE);

  // ---------------------------------------------------------------- request latch
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_cmd  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_cmd  <= i_command;
      r_addr <= i_address;
      r_data <= i_data;
    end
  end

  // ---------------------------------------------------------------- transmitter
  always_comb begin
    w_frame_byte = 8'h00;
    unique case (r_tx_byte)
      3'd0:    w_frame_byte = r_cmd;
      3'd1:    w_frame_byte = {1'b0, r_addr[14:8]};
      3'd2:    w_frame_byte = r_addr[7:0];
      3'd3:    w_frame_byte = r_data[31:24];
      3'd4:    w_frame_byte = r_data[23:16];
      3'd5:    w_frame_byte = r_data[15:8];
      3'd6:    w_frame_byte = r_data[7:0];
      default: w_frame_byte = 8'h00;
    endcase
  end

  assign w_bit_m1 = r_tx_bit - 4'd1;

  always_comb begin
    w_tx_bit = 1'b1;
    if (r_state == S_TX_BYTE) begin
      if (r_tx_bit == 4'd0)      w_tx_bit = 1'b0;
      else if (r_tx_bit == 4'd9) w_tx_bit = 1'b1;
      else                       w_tx_bit = w_frame_byte[w_bit_m1[2:0]];
    end
  end

  // Decoded straight from state so reset forces the line high immediately.
  assign o_tx = w_tx_bit;

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_tx_clk  <= '0;
      r_tx_bit  <= '0;
      r_tx_byte <= '0;
    end else if (w_accept) begin
      r_tx_clk  <= '0;
      r_tx_bit  <= '0;
      r_tx_byte <= '0;
    end else if (r_state == S_TX_BYTE) begin
      if (w_tx_bit_end) begin
        r_tx_clk <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_bit  <= '0;
          r_tx_byte <= r_tx_byte + 3'd1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_clk <= r_tx_clk + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  // s1/s2 form the synchroniser; s3 only remembers the previous level for
  // falling-edge detection.
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_rx_active <= 1'b0;
      r_rx_cnt    <= '0;
      r_rx_bitn   <= '0;
      r_rx_sh     <= '0;
      r_rx_vld    <= 1'b0;
      r_rx_dat    <= '0;
    end else begin
      r_rx_vld <= 1'b0;
      if (r_rx_active) begin
        if (r_rx_cnt == '0) begin
          r_rx_cnt <= BIT_LAST;
          if (r_rx_bitn == 4'd0) begin
            // Line back high at the start-bit centre: a glitch, not a byte.
            if (r_rx_s2) r_rx_active <= 1'b0;
            else         r_rx_bitn   <= 4'd1;
          end else if (r_rx_bitn <= 4'd8) begin
            r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bitn <= r_rx_bitn + 4'd1;
          end else begin
            // Stop-bit centre: return to hunting so back-to-back bytes work.
            r_rx_active <= 1'b0;
            if (r_rx_s2) begin
              r_rx_vld <= 1'b1;
              r_rx_dat <= r_rx_sh;
            end
          end
        end else begin
          r_rx_cnt <= r_rx_cnt - CW'(1);
        end
      end else if (r_rx_s3 && !r_rx_s2) begin
        r_rx_active <= 1'b1;
        r_rx_cnt    <= HALF_LAST;
        r_rx_bitn   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- response window
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_tmo      <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (w_tx_frame_end) begin
      r_tmo      <= TMO_LOAD;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (r_state == S_RESP) begin
      if (r_rx_vld) begin
        r_shift    <= {r_shift[23:0], r_rx_dat};
        r_byte_cnt <= (r_byte_cnt == 3'd5) ? 3'd5 : r_byte_cnt + 3'd1;
        r_tmo      <= TMO_LOAD;
      end else if (r_tmo != '0) begin
        r_tmo <= r_tmo - TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- result
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_status <= 2'b00;
      r_err    <= 2'b00;
      r_rdata  <= '0;
    end else if (w_tmo_expire) begin
      if (r_byte_cnt == 3'd0 && r_cmd == 8'h00) begin
        r_status <= 2'b00;
      end else if (r_byte_cnt == 3'd4 && r_cmd == 8'h01) begin
        r_status <= 2'b01;
        r_rdata  <= r_shift;
      end else if (r_byte_cnt == 3'd1 && w_err_byte) begin
        r_status <= 2'b10;
        r_err    <= r_shift[1:0];
      end else begin
        r_status <= 2'b11;
      end
    end
  end

  assign o_status     = r_status;
  assign o_error_code = r_err;
  assign o_rdata      = r_rdata;

endmodule

// File: tb/tb_command_initiator.sv
// Bench for command_initiator with CLKS_PER_BIT=4, RESP_TIMEOUT=100.
// Stimulus pushes expected TX bytes and expected results into queues; two
// monitors decode o_tx and catch o_done, popping and comparing independently.
module tb_command_initiator;

  localparam int CPB = 4;
  localparam int TMO = 100;

  logic        sys_clk = 1'b0;
  logic        sw_0;
  logic        i_start;
  logic [7:0]  i_command;
  logic [14:0] i_address;
  logic [31:0] i_data;
  logic        i_rx;
  logic        o_tx;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_status;
  logic [1:0]  o_error_code;
  logic [31:0] o_rdata;

  command_initiator #(.CLKS_PER_BIT(CPB), .RESP_TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sw_0(sw_0), .i_start(i_start), .i_command(i_command),
    .i_address(i_address), .i_data(i_data), .i_rx(i_rx), .o_tx(o_tx),
    .o_busy(o_busy), .o_done(o_done), .o_status(o_status),
    .o_error_code(o_error_code), .o_rdata(o_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  err;
    bit          chk_err;
    logic [31:0] rd;
    int          busy;   // expected busy cycles, -1 = not checked
  } res_t;

  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  int ntot = 0;
  int nbad = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int txm_pos = -1;
  logic [7:0] txm_sh;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // TX monitor: samples o_tx at the centre of each bit.
  always @(negedge sys_clk) begin
    if (!sw_0) begin
      txm_pos = -1;
    end else begin
      if (txm_pos < 0) begin
        if (o_tx == 1'b0) txm_pos = 0;
      end else begin
        txm_pos++;
      end
      if (txm_pos >= 0 && (txm_pos % CPB) == CPB / 2) begin
        if (txm_pos / CPB >= 1 && txm_pos / CPB <= 8) begin
          txm_sh[txm_pos / CPB - 1] = o_tx;
        end else if (txm_pos / CPB == 9) begin
          chk("tx_stop_bit", o_tx, 1);
          if (exp_tx.size() == 0) begin
            ntot++; nbad++;
            $display("FAIL tx_unexpected_byte: got %h expected none", txm_sh);
          end else begin
            chk("tx_byte", txm_sh, exp_tx.pop_front());
          end
          txm_pos = -1;
        end
      end
    end
  end

  // Completion monitor.
  always @(negedge sys_clk) begin
    res_t r;
    if (!sw_0) begin
      busy_cyc = 0;
    end else begin
      if (o_busy) busy_cyc++;
      if (o_done) begin
        done_cnt++;
        chk("busy_low_at_done", o_busy, 0);
        if (exp_res.size() == 0) begin
          ntot++; nbad++;
          $display("FAIL unexpected_done: got done expected none at %0t", $time);
        end else begin
          r = exp_res.pop_front();
          chk("status", o_status, r.st);
          chk("rdata", o_rdata, r.rd);
          if (r.chk_err) chk("error_code", o_error_code, r.err);
          if (r.busy >= 0) chk("busy_cycles", busy_cyc, r.busy);
        end
        busy_cyc = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    tick(CPB);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    i_rx = 1'b1;
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [14:0] addr,
                            input logic [31:0] data);
    exp_tx.push_back(cmd);
    exp_tx.push_back({1'b0, addr[14:8]});
    exp_tx.push_back(addr[7:0]);
    if (cmd == 8'h00) begin
      exp_tx.push_back(data[31:24]);
      exp_tx.push_back(data[23:16]);
      exp_tx.push_back(data[15:8]);
      exp_tx.push_back(data[7:0]);
    end
  endtask

  task automatic do_txn(input logic [7:0] cmd, input logic [14:0] addr,
                        input logic [31:0] data, input int nrx,
                        input logic [39:0] rx, input bit bad_stop, input bit retrig,
                        input logic [1:0] st, input logic [1:0] err, input bit chk_err,
                        input logic [31:0] rd, input int busy);
    res_t r;
    int ntx;
    int d0;
    int c;
    ntx = (cmd == 8'h00) ? 7 : 3;
    push_frame(cmd, addr, data);
    r.st = st; r.err = err; r.chk_err = chk_err; r.rd = rd; r.busy = busy;
    exp_res.push_back(r);
    i_command = cmd; i_address = addr; i_data = data; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    if (retrig) begin
      tick(50);
      i_command = 8'h01; i_address = 15'h7777; i_data = 32'h0; i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
      tick(ntx * 10 * CPB + 3 - 51);
    end else begin
      tick(ntx * 10 * CPB + 3);
    end
    for (int k = 0; k < nrx; k++)
      uart_send(rx[39 - 8 * k -: 8], !(bad_stop && k == nrx - 1));
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < 2000) begin
      @(posedge sys_clk);
      c++;
    end
    #1;
    if (done_cnt == d0) begin
      ntot++; nbad++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sw_0 = 1'b0; i_start = 1'b0; i_command = '0; i_address = '0; i_data = '0;
    i_rx = 1'b1;
    tick(3);
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_status", o_status, 0);
    chk("rst_err", o_error_code, 0);
    chk("rst_rdata", o_rdata, 0);
    sw_0 = 1'b1;
    tick(2);

    // write, no reply: 280 TX cycles + 100 window cycles of busy
    do_txn(8'h00, 15'h1234, 32'hDEADBEEF, 0, 40'h0, 0, 0, 2'b00, 2'b00, 0, 32'h0, 380);
    // read, four data bytes
    do_txn(8'h01, 15'h7FFF, 32'h0, 4, 40'hCAFEBABE00, 0, 0, 2'b01, 2'b00, 0, 32'hCAFEBABE, -1);
    // read, device error 0x02
    do_txn(8'h01, 15'h0010, 32'h0, 1, 40'h0200000000, 0, 0, 2'b10, 2'b10, 1, 32'hCAFEBABE, -1);
    // read, 3 bytes
    do_txn(8'h01, 15'h0020, 32'h0, 3, 40'h1122330000, 0, 0, 2'b11, 2'b00, 0, 32'hCAFEBABE, -1);
    // read, 5 bytes
    do_txn(8'h01, 15'h0030, 32'h0, 5, 40'h0102030405, 0, 0, 2'b11, 2'b00, 0, 32'hCAFEBABE, -1);
    // read, single byte with a broken stop bit
    do_txn(8'h01, 15'h0040, 32'h0, 1, 40'h0300000000, 1, 0, 2'b11, 2'b00, 0, 32'hCAFEBABE, -1);
    // write with a second i_start during TX
    do_txn(8'h00, 15'h0ABC, 32'h01234567, 0, 40'h0, 0, 1, 2'b00, 2'b00, 0, 32'hCAFEBABE, -1);
    // unknown command, device error 0x01
    do_txn(8'h5A, 15'h0102, 32'h0, 1, 40'h0100000000, 0, 0, 2'b10, 2'b01, 1, 32'hCAFEBABE, -1);
    // write answered by 0x00
    do_txn(8'h00, 15'h0000, 32'h11223344, 1, 40'h0000000000, 0, 0, 2'b11, 2'b00, 0, 32'hCAFEBABE, -1);

    // reset in the middle of the second byte of a write
    exp_tx.push_back(8'h00);
    i_command = 8'h00; i_address = 15'h1234; i_data = 32'hDEADBEEF; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(42);
    chk("tx_start_bit_byte2", o_tx, 0);
    sw_0 = 1'b0;
    #1;
    chk("mid_rst_tx", o_tx, 1);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_status", o_status, 0);
    chk("mid_rst_err", o_error_code, 0);
    chk("mid_rst_rdata", o_rdata, 0);
    tick(3);
    sw_0 = 1'b1;
    // first i_start straight after release
    do_txn(8'h01, 15'h0001, 32'h0, 4, 40'hDEAD000100, 0, 0, 2'b01, 2'b00, 0, 32'hDEAD0001, -1);

    tick(20);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/command_initiator.md
COMMAND_INITIATOR -- requirements
Module: command_initiator

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: sys_clk cycles per UART bit (8N1).
REQ-002 SHALL have parameter RESP_TIMEOUT, default 200000: idle sys_clk cycles that close the response window.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- sys_clk  in  1  clock
- sw_0  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle command request
- i_command  in  8  0x00 = write, 0x01 = read, other values sent as-is
- i_address  in  15  word address
- i_data  in  32  write data
- i_rx  in  1  UART serial from responder
- o_tx  out  1  UART serial to responder
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle completion pulse
- o_status  out  2  00 write ok, 01 read data, 10 device error, 11 protocol error
- o_error_code  out  2  responder error byte, low 2 bits
- o_rdata  out  32  read word

Function
REQ-005 On i_start in IDLE, SHALL latch i_command, i_address and i_data, assert o_busy on the next cycle, and enter TX_BYTE.
REQ-006 i_start while o_busy=1 SHALL be ignored, with no effect on the running transaction.
REQ-007 Frame bytes, in order:
- i_command
- {1'b0, i_address[14:8]}
- i_address[7:0]
- for i_command=0x00 only: i_data[31:24], [23:16], [15:8], [7:0]
- frame length is therefore 7 bytes for write, 3 bytes otherwise.
REQ-008 Each byte SHALL be sent as: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly CLKS_PER_BIT cycles; bytes are back-to-back with no idle gap.
REQ-009 o_tx SHALL be 1 whenever no bit is being driven.
REQ-010 States SHALL be IDLE, TX_BYTE, RESP, DONE:
- IDLE -> TX_BYTE on accepted i_start
- TX_BYTE -> RESP after the stop bit of the last frame byte
- RESP -> DONE on timeout
- DONE -> IDLE after one cycle
REQ-011 The RX path SHALL synchronise i_rx through 2 flops.
REQ-012 The RX path SHALL detect a start bit on a falling edge, sample each bit at its centre (CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT), and discard a byte whose stop bit is 0.
REQ-013 In RESP, each received byte SHALL shift into a 32-bit register MSB-first (big-endian), increment a saturating byte counter (max 5), and reload the timeout counter.
REQ-014 The RESP timeout counter SHALL start at RESP_TIMEOUT on RESP entry; RESP ends when it reaches 0.
REQ-015 Bytes received outside RESP SHALL be discarded.
REQ-016 On timeout, the result SHALL be decided by latched command and received byte count:
- 0 bytes and write -> status 00
- 4 bytes and read -> status 01, o_rdata = received word
- 1 byte with value 0x01-0x03 -> status 10, o_error_code = value[1:0]
- any other combination -> status 11
REQ-017 In DONE, o_done SHALL be 1 for exactly one cycle and o_busy SHALL drop in the same cycle.
REQ-018 o_status, o_error_code and o_rdata SHALL hold their values until the next DONE.
REQ-019 o_rdata SHALL update only on status 01.

Reset
REQ-020 sw_0=0 SHALL immediately force the following, regardless of state, including mid-byte on TX or RX:
- state IDLE, o_tx=1, o_busy=0, o_done=0
- o_status=00, o_error_code=00, o_rdata=0
- byte counter and timeout counter 0
- RX receiver idle
REQ-021 After sw_0 rises, the first i_start SHALL be accepted on the following sys_clk edge.

Verification (bench: CLKS_PER_BIT=4, RESP_TIMEOUT=100)
REQ-022 Write, addr 0x1234, data 0xDEADBEEF, no reply -> o_tx carries 00 12 34 DE AD BE EF (280 bit-cycles); o_done 100 cycles after the last stop bit; o_status=00.
REQ-023 Read, addr 0x7FFF, responder returns 0xCA 0xFE 0xBA 0xBE -> TX bytes 01 7F FF; o_status=01; o_rdata=0xCAFEBABE.
REQ-024 Read, responder returns single byte 0x02 -> o_status=10, o_error_code=10, o_rdata unchanged.
REQ-025 Read, responder returns 3 bytes, or 5 bytes, or one byte with a bad stop bit -> o_status=11.
REQ-026 i_start pulsed again during TX -> frame unchanged, only one o_done.
REQ-027 sw_0 low mid-byte 2 of a write -> o_tx=1 and o_busy=0 within the same cycle; a new read afterwards completes normally.
